input_accumulator: RTL

INPUT_ACCUMULATOR -- requirements
Module: input_accumulator

---
 rtl/input_accumulator_pkg.sv | 7 +
 rtl/input_accumulator.sv | 77 +++++++
 2 files changed

// File: rtl/input_accumulator_pkg.sv
// input_accumulator_pkg: shared default widths and window state encoding
package input_accumulator_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_SUM_W  = 28;
  localparam int DEF_CNT_W  = 20;
  typedef enum logic [1:0] {IDLE, ACCUM, SAT} acc_state_t;
endpackage

// File: rtl/input_accumulator.sv
// input_accumulator: windowed sample sum/count with double-buffered outputs for a divider
module input_accumulator
  import input_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = DEF_SUM_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              ValidIn,
  input  logic              LastIn,
  input  logic              Abort,
  output logic [SUM_W-1:0]  SumOut,
  output logic [CNT_W-1:0]  CountOut,
  output logic              StartOut,
  output logic              Overflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  acc_state_t state, state_nx;
  logic [SUM_W-1:0] sum, sum_nx, sum_inc;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic flag, flag_nx, take, close, sat;
  assign take    = ValidIn && !Abort;
  assign close   = take && LastIn;
  assign sat     = state == SAT;
  assign sum_inc = sum + SUM_W'(DataIn);
  assign cnt_inc = cnt + 1'b1;
  always_comb begin
    state_nx = state;
    sum_nx   = sum;
    cnt_nx   = cnt;
    flag_nx  = flag;
    if (Abort || close) begin
      state_nx = IDLE;
      sum_nx   = '0;
      cnt_nx   = '0;
      flag_nx  = 1'b0;
    end else if (take && sat) begin
      flag_nx  = 1'b1;
    end else if (take) begin
      sum_nx   = sum_inc;
      cnt_nx   = cnt_inc;
      state_nx = (cnt_inc == CNT_MAX) ? SAT : ACCUM;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sum   <= '0;
      cnt   <= '0;
      flag  <= 1'b0;
    end else begin
      state <= state_nx;
      sum   <= sum_nx;
      cnt   <= cnt_nx;
      flag  <= flag_nx;
    end
  end
  // A closing sample in SAT is dropped, so the emitted totals skip it
  always_ff @(posedge clock) begin
    if (reset) begin
      SumOut   <= '0;
      CountOut <= '0;
      StartOut <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      StartOut <= close;
      if (close) begin
        SumOut   <= sat ? sum : sum_inc;
        CountOut <= sat ? cnt : cnt_inc;
        Overflow <= sat || flag;
      end
    end
  end
endmodule
